vram_console_writer: RTL

//  Text-console writer; the producer side of the VRAM read by the LCD text renderer.

---
 rtl/vram_console_writer_pkg.sv | 27 ++
 rtl/vram_console_writer_if.sv | 27 ++
 rtl/vram_console_writer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/vram_console_writer_pkg.sv
// rtl/vram_console_writer_pkg.sv - console geometry, control codes and FSM states
package vram_console_writer_pkg;

    localparam int COLS   = 60;
    localparam int ROWS   = 17;
    localparam int ADDR_W = 10;
    localparam int CELLS  = COLS * ROWS;

    localparam logic [7:0] BLANK = 8'h20;
    localparam logic [7:0] CC_LF = 8'h0A;
    localparam logic [7:0] CC_CR = 8'h0D;
    localparam logic [7:0] CC_BS = 8'h08;
    localparam logic [7:0] CC_FF = 8'h0C;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_SCROLL_RD,
        ST_SCROLL_WR,
        ST_BLANK_ROW
    } state_e;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= 8'h20) && (b != 8'h7F);
    endfunction

endpackage

// File: rtl/vram_console_writer_if.sv
// rtl/vram_console_writer_if.sv - byte stream, VRAM port A and cursor/status bundle
interface vram_console_writer_if;
    import vram_console_writer_pkg::*;

    logic              ch_valid;
    logic [7:0]        ch_data;
    logic              ch_ready;
    logic              clear;
    logic [ADDR_W-1:0] v_ada;
    logic [7:0]        v_din;
    logic              v_we;
    logic [7:0]        v_douta;
    logic [5:0]        cur_col;
    logic [4:0]        cur_row;
    logic              busy;

    modport slave (
        input  ch_valid, ch_data, clear, v_douta,
        output ch_ready, v_ada, v_din, v_we, cur_col, cur_row, busy
    );

    modport master (
        output ch_valid, ch_data, clear, v_douta,
        input  ch_ready, v_ada, v_din, v_we, cur_col, cur_row, busy
    );

endinterface

// File: rtl/vram_console_writer.sv
// rtl/vram_console_writer.sv - text console writer: cursor, control codes, wrap, scroll, clear
module vram_console_writer
    import vram_console_writer_pkg::*;
(
    input  logic                  PixelClk,
    input  logic                  nRST,
    vram_console_writer_if.slave  bus
);

    localparam logic [ADDR_W-1:0] COLS_A        = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] LAST_CELL     = ADDR_W'(CELLS - 1);
    localparam logic [ADDR_W-1:0] LAST_ROW_BASE = ADDR_W'((ROWS - 1) * COLS);
    localparam logic [ADDR_W-1:0] ONE_A         = ADDR_W'(1);
    localparam logic [5:0]        LAST_COL      = 6'(COLS - 1);
    localparam logic [4:0]        LAST_ROW      = 5'(ROWS - 1);

    state_e            state_q, state_d;
    logic [5:0]        col_q, col_d;
    logic [4:0]        row_q, row_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [ADDR_W-1:0] fill_q, fill_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] ada_q, ada_d;
    logic [7:0]        din_q, din_d;
    logic              we_q, we_d;
    logic              busy_q, busy_d;
    logic [ADDR_W-1:0] cur_addr;
    logic              newline;

    assign cur_addr = row_base_q + ADDR_W'(col_q);

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        row_base_d = row_base_q;
        fill_d     = fill_q;
        src_d      = src_q;
        ada_d      = ada_q;
        din_d      = din_q;
        we_d       = 1'b0;
        newline    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.clear) begin
                    state_d = ST_CLEAR;
                    fill_d  = '0;
                end else if (bus.ch_valid) begin
                    if (is_printable(bus.ch_data)) begin
                        ada_d = cur_addr;
                        din_d = bus.ch_data;
                        we_d  = 1'b1;
                        if (col_q == LAST_COL) begin
                            col_d   = '0;
                            newline = 1'b1;
                        end else begin
                            col_d = col_q + 6'd1;
                        end
                    end else if (bus.ch_data == CC_LF) begin
                        col_d   = '0;
                        newline = 1'b1;
                    end else if (bus.ch_data == CC_CR) begin
                        col_d = '0;
                    end else if (bus.ch_data == CC_BS) begin
                        if (col_q != '0) begin
                            col_d = col_q - 6'd1;
                            ada_d = cur_addr - ONE_A;
                            din_d = BLANK;
                            we_d  = 1'b1;
                        end
                    end else if (bus.ch_data == CC_FF) begin
                        state_d = ST_CLEAR;
                        fill_d  = '0;
                    end
                end
            end
            ST_CLEAR: begin
                ada_d = fill_q;
                din_d = BLANK;
                we_d  = 1'b1;
                if (fill_q == LAST_CELL) begin
                    state_d    = ST_IDLE;
                    col_d      = '0;
                    row_d      = '0;
                    row_base_d = '0;
                end else begin
                    fill_d = fill_q + ONE_A;
                end
            end
            ST_SCROLL_RD: begin
                ada_d   = src_q;
                state_d = ST_SCROLL_WR;
            end
            // v_douta already reflects the address presented by SCROLL_RD
            ST_SCROLL_WR: begin
                ada_d = src_q - COLS_A;
                din_d = bus.v_douta;
                we_d  = 1'b1;
                if (src_q == LAST_CELL) begin
                    state_d = ST_BLANK_ROW;
                    fill_d  = LAST_ROW_BASE;
                end else begin
                    src_d   = src_q + ONE_A;
                    state_d = ST_SCROLL_RD;
                end
            end
            ST_BLANK_ROW: begin
                ada_d = fill_q;
                din_d = BLANK;
                we_d  = 1'b1;
                if (fill_q == LAST_CELL) begin
                    state_d = ST_IDLE;
                    col_d   = '0;
                end else begin
                    fill_d = fill_q + ONE_A;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                fill_d  = '0;
            end
        endcase

        // Bottom row never advances; the whole screen moves up instead.
        if (newline) begin
            if (row_q != LAST_ROW) begin
                row_d      = row_q + 5'd1;
                row_base_d = row_base_q + COLS_A;
            end else begin
                state_d = ST_SCROLL_RD;
                src_d   = COLS_A;
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            state_q    <= ST_CLEAR;
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= '0;
            fill_q     <= '0;
            src_q      <= '0;
            ada_q      <= '0;
            din_q      <= '0;
            we_q       <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            row_base_q <= row_base_d;
            fill_q     <= fill_d;
            src_q      <= src_d;
            ada_q      <= ada_d;
            din_q      <= din_d;
            we_q       <= we_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.ch_ready = (state_q == ST_IDLE) && !bus.clear;
    assign bus.v_ada    = ada_q;
    assign bus.v_din    = din_q;
    assign bus.v_we     = we_q;
    assign bus.cur_col  = col_q;
    assign bus.cur_row  = row_q;
    assign bus.busy     = busy_q;

endmodule
